// File: rtl/ram64_pkg.sv
// Shared Hack word constants plus the dmux8way / mux8way16 gate equivalents
// used by both the ram8 banks and the ram64 top level.
package ram64_pkg;

  localparam int          HACK_WORD       = 16;
  localparam logic [15:0] HACK_RESET_WORD = 16'h0000;

  // One-hot routing of a write strobe to one of eight destinations.
  function automatic logic [7:0] dmux8way(input logic in, input logic [2:0] sel);
    dmux8way = in ? (8'b0000_0001 << sel) : 8'b0000_0000;
  endfunction

  function automatic logic [HACK_WORD-1:0] mux8way16(
    input logic [7:0][HACK_WORD-1:0] d,
    input logic [2:0]                sel
  );
    mux8way16 = d[sel];
  endfunction

endpackage

// File: rtl/ram64_ram8.sv
// Eight-word bank: a dmux8way steers load to one register, a mux8way16 reads
// the addressed register back. Storage clears asynchronously on rst_n low.
module ram64_ram8
  import ram64_pkg::*;
#(
  parameter int WIDTH = HACK_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [7:0]            load_sel;
  logic [7:0][WIDTH-1:0] word_q;
  logic [7:0][WIDTH-1:0] word_d;

  assign load_sel = dmux8way(load, address);

  always_comb begin
    word_d = word_q;
    for (int i = 0; i < 8; i++) begin
      if (load_sel[i]) word_d[i] = in;
    end
  end

  // Async clear has priority, so a load held during reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= {8{HACK_RESET_WORD}};
    else        word_q <= word_d;
  end

  assign out = mux8way16(word_q, address);

endmodule

// File: rtl/ram64.sv
// 64 x 16 Hack data memory: address[5:3] picks one of eight ram8 banks for both
// the write strobe and the read-back mux; address[2:0] picks the word in-bank.
module ram64
  import ram64_pkg::*;
#(
  parameter int WIDTH = HACK_WORD,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [5:0]       address,
  output logic [WIDTH-1:0] out
);

  localparam int BANKS = DEPTH / 8;

  logic [BANKS-1:0]            bank_load;
  logic [BANKS-1:0][WIDTH-1:0] bank_out;

  assign bank_load = dmux8way(load, address[5:3]);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram64_ram8 #(.WIDTH(WIDTH)) u_ram8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (bank_load[b]),
      .address (address[2:0]),
      .out     (bank_out[b])
    );
  end

  assign out = mux8way16(bank_out, address[5:3]);

endmodule
